// File: rtl/ram_burst_ctrl.sv
// Burst controller in front of a single-port synchronous RAM.
// Write bursts stream words from wr_* into consecutive addresses; read bursts
// stream consecutive addresses out through a 2-entry FIFO with a bypass path,
// so the first word appears the cycle after its read is issued.
module ram_burst_ctrl #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] base_q;
    logic [AW:0]   len_q;
    logic [AW:0]   iss_q;               // words written, or reads issued
    logic [AW:0]   pop_q;               // words delivered on the read stream
    logic [1:0]    cnt_q;               // words held in the FIFO storage
    logic          inf_q;               // a read was issued last cycle
    logic          rptr_q, wptr_q;
    logic [DW-1:0] mem_q [2];

    logic          wr_xfer, rd_issue, pop, rd_vld;
    logic [2:0]    occ;
    logic [DW-1:0] head;
    logic [AW-1:0] cur_addr;

    // Datapath decode: transfers, FIFO occupancy and read issue decision.
    always_comb begin
        cur_addr = base_q + iss_q[AW-1:0];
        wr_xfer  = (state_q == WR) && wr_valid;
        // The word returning from RAM this cycle is visible immediately (bypass).
        rd_vld   = (state_q == RD) && ((cnt_q != 2'd0) || inf_q);
        head     = (cnt_q != 2'd0) ? mem_q[rptr_q] : ram_dout;
        pop      = rd_vld && rd_ready;
        // Occupancy after this cycle's push/pop, before any new issue.
        occ      = {1'b0, cnt_q} + {2'b00, inf_q} - {2'b00, pop};
        rd_issue = (state_q == RD) && (iss_q < len_q) && (occ < 3'd2);
    end

    // Next-state logic and combinational outputs.
    always_comb begin
        state_d  = state_q;
        busy     = (state_q != IDLE);
        done     = (state_q == FIN);
        wr_ready = (state_q == WR);
        rd_valid = rd_vld;
        rd_data  = rd_vld ? head : '0;
        ram_en   = wr_xfer || rd_issue;
        ram_we   = wr_xfer;
        ram_addr = (wr_xfer || rd_issue) ? cur_addr : '0;
        ram_din  = wr_xfer ? wr_data : '0;
        case (state_q)
            IDLE: if (start) begin
                if (len == '0)  state_d = FIN;
                else if (mode)  state_d = WR;
                else            state_d = RD;
            end
            WR:   if (wr_xfer && (iss_q + 1'b1 == len_q)) state_d = FIN;
            RD:   if (pop && (pop_q + 1'b1 == len_q))     state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Burst bookkeeping and read FIFO.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            base_q   <= '0;
            len_q    <= '0;
            iss_q    <= '0;
            pop_q    <= '0;
            cnt_q    <= '0;
            inf_q    <= 1'b0;
            rptr_q   <= 1'b0;
            wptr_q   <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (state_q == IDLE) begin
            if (start) begin
                base_q <= base_addr;
                len_q  <= len;
            end
            iss_q  <= '0;
            pop_q  <= '0;
            cnt_q  <= '0;
            inf_q  <= 1'b0;
            rptr_q <= 1'b0;
            wptr_q <= 1'b0;
        end else begin
            if (wr_xfer || rd_issue) iss_q <= iss_q + 1'b1;
            if (pop) begin
                pop_q  <= pop_q + 1'b1;
                rptr_q <= ~rptr_q;
            end
            // Returning word is always written; if it was bypassed and popped
            // the read pointer advances past it in the same cycle.
            if (inf_q) begin
                mem_q[wptr_q] <= ram_dout;
                wptr_q        <= ~wptr_q;
            end
            inf_q <= rd_issue;
            cnt_q <= occ[1:0];
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Scoreboard bench for ram_burst_ctrl: stimulus pushes expected RAM writes,
// read-stream words and done cycles; a negedge monitor pops and compares.
module tb_ram_burst_ctrl;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          sys_rst;
    logic          start, mode;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy, done;
    logic [DW-1:0] wr_data;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_ready;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    ram_burst_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .sys_rst(sys_rst), .start(start), .mode(mode),
        .base_addr(base_addr), .len(len), .busy(busy), .done(done),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous RAM, one-cycle read latency.
    logic [DW-1:0] ram [2**AW];
    always @(posedge clk) begin
        if (ram_en && ram_we)  ram[ram_addr] <= ram_din;
        if (ram_en && !ram_we) ram_dout <= ram[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    logic [AW-1:0] exp_wa[$];
    logic [DW-1:0] exp_wd[$];
    logic [DW-1:0] exp_rd[$];
    int            exp_done[$];     // -1: done expected, cycle not checked
    logic [DW-1:0] shadow [2**AW];

    int issued, popped;

    // Monitor: compares every RAM write, read-stream pop and done pulse.
    always @(negedge clk) begin
        if (sys_rst) begin
            issued = 0;
            popped = 0;
        end else begin
            if (ram_en && ram_we) begin
                if (exp_wa.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    chk("wr_addr", 32'(ram_addr), 32'(exp_wa.pop_front()));
                    chk("wr_data", 32'(ram_din), 32'(exp_wd.pop_front()));
                end
            end
            if (ram_en && !ram_we) issued++;
            if (rd_valid && rd_ready) begin
                popped++;
                if (exp_rd.size() == 0) chk("unexpected_pop", 1, 0);
                else chk("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
            end
            if (ram_en && !ram_we) chk("occupancy_le2", 32'(issued - popped <= 2), 1);
            if (done) begin
                if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    int e;
                    e = exp_done.pop_front();
                    if (e >= 0) chk("done_cycle", 32'(cyc), 32'(e));
                    chk("busy_at_done", 32'(busy), 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic m, input logic [AW-1:0] b,
                               input logic [AW:0] l, output int k);
        start = 1'b1; mode = m; base_addr = b; len = l;
        tick();
        start = 1'b0;
        k = cyc;
    endtask

    task automatic write_burst(input logic [AW-1:0] b, input logic [DW-1:0] d0,
                               input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        int k;
        logic [DW-1:0] d [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        for (int i = 0; i < 3; i++) begin
            exp_wa.push_back(b + AW'(i));
            exp_wd.push_back(d[i]);
            shadow[b + AW'(i)] = d[i];
        end
        start_burst(1'b1, b, 5'd3, k);
        exp_done.push_back(k + 3);
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = d[i];
            tick();
        end
        wr_valid = 1'b0;
        tick(); tick();
    endtask

    initial begin
        int k;
        logic [3:0] pat;
        pat = 4'b1001;
        sys_rst = 1'b1; start = 0; mode = 0; base_addr = 0; len = 0;
        wr_data = 0; wr_valid = 0; rd_ready = 0;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ram_en", 32'({ram_en, ram_we}), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_ram_addr_din", 32'({ram_addr, ram_din}), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        @(negedge clk); sys_rst = 1'b0;
        tick();

        // Write A,B,C to 2..4 then X,Y,Z to 14,15,0 (address wrap).
        write_burst(4'd2, 16'hA0A0, 16'hB1B1, 16'hC2C2);
        write_burst(4'd14, 16'h0E0E, 16'h0F0F, 16'h0101);

        // Write 1..7 with one idle wr_valid cycle: 7 transfers over 8 cycles.
        for (int i = 0; i < 7; i++) begin
            exp_wa.push_back(AW'(1 + i));
            exp_wd.push_back(16'h1000 + DW'(i));
            shadow[1 + i] = 16'h1000 + DW'(i);
        end
        start_burst(1'b1, 4'd1, 5'd7, k);
        exp_done.push_back(k + 8);
        for (int i = 0, n = 0; i < 8; i++) begin
            wr_valid = (i != 3);
            wr_data  = 16'h1000 + DW'(n);
            tick();
            if (i != 3) n++;
        end
        wr_valid = 1'b0;
        tick(); tick();

        // Wrap read 14,15,0 at full rate.
        rd_ready = 1'b1;
        exp_rd.push_back(16'h0E0E); exp_rd.push_back(16'h0F0F); exp_rd.push_back(16'h0101);
        start_burst(1'b0, 4'd14, 5'd3, k);
        chk("rd_valid_latency_lo", 32'(rd_valid), 0);
        exp_done.push_back(k + 4);
        tick();
        chk("rd_valid_latency_hi", 32'(rd_valid), 1);
        repeat (5) tick();

        // Zero-length burst; a start during FIN must be ignored.
        start_burst(1'b0, 4'd5, 5'd0, k);
        exp_done.push_back(k);
        chk("len0_no_ram_en", 32'(ram_en), 0);
        start = 1'b1; mode = 1'b1; len = 5'd2;
        tick();
        start = 1'b0;
        chk("ignored_start_busy", 32'(busy), 0);
        chk("ignored_start_wr_ready", 32'(wr_ready), 0);
        tick();

        // Backpressure read of 0..7 with rd_ready 1,0,0,1,...
        for (int i = 0; i < 8; i++) exp_rd.push_back(shadow[i]);
        exp_done.push_back(-1);
        rd_ready = pat[0];
        start_burst(1'b0, 4'd0, 5'd8, k);
        for (int i = 1; i < 48; i++) begin
            rd_ready = pat[i % 4];
            tick();
        end
        rd_ready = 1'b1;
        tick();
        chk("bp_all_words", 32'(exp_rd.size()), 0);
        chk("bp_done_seen", 32'(exp_done.size()), 0);

        // Reset in the middle of a stalled read with two buffered words.
        rd_ready = 1'b0;
        start_burst(1'b0, 4'd1, 5'd4, k);
        repeat (4) tick();
        chk("pre_rst_rd_valid", 32'(rd_valid), 1);
        #2 sys_rst = 1'b1;
        #1;
        chk("mid_rst_rd_valid", 32'(rd_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        @(negedge clk); sys_rst = 1'b0;
        rd_ready = 1'b1;
        tick();
        exp_wa.push_back(4'd9); exp_wd.push_back(16'h5A5A);
        start_burst(1'b1, 4'd9, 5'd1, k);
        exp_done.push_back(k + 1);
        wr_valid = 1'b1; wr_data = 16'h5A5A;
        tick();
        wr_valid = 1'b0;
        repeat (3) tick();

        chk("left_writes", 32'(exp_wa.size()), 0);
        chk("left_reads", 32'(exp_rd.size()), 0);
        chk("left_dones", 32'(exp_done.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
